// File: rtl/avalon_mem_pkg.sv
// -----------------------------------------------------------------------------
// avalon_mem_pkg
//
// Shared definitions for the wait-state Avalon-MM memory:
//   state_t            - transfer FSM states (IDLE, WAIT, ACK)
//   DEFAULT_BASE_ADDR  - default byte address of word 0 (boot vector region)
//   CNT_W              - width of the wait-state down-counter (0..15 stalls)
//   in_window()        - true when a byte address falls inside the aligned
//                        2^(addr_w+2)-byte window that starts at base
// -----------------------------------------------------------------------------
package avalon_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hBFC0_0000;
    localparam int unsigned CNT_W             = 4;

    // The window is aligned to its own size, so membership reduces to the
    // upper address bits matching those of the base.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int unsigned addr_w);
        logic [31:0] diff;
        diff = addr ^ base;
        return ((diff >> (addr_w + 2)) == 32'd0);
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// -----------------------------------------------------------------------------
// mem_word_array
//
// 2^ADDR_W x 32-bit storage with two write ports and one synchronous read port.
//
// Ports:
//   clk, rst_n                    - clock; async active-low reset (read register only,
//                                   the array itself is never cleared)
//   bus_we, bus_addr, bus_data,
//   bus_be                        - bus write port with per-byte lane enables
//   load_en, load_addr, load_data - loader write port; wins over the bus port
//                                   when both hit the same word on one edge
//   rd_en, rd_zero, rd_addr       - read request; rd_zero returns 0 instead of
//                                   the array word (used for faulty addresses)
//   rd_data                       - registered read data, holds until next rd_en
// -----------------------------------------------------------------------------
module mem_word_array #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [31:0]       bus_data,
    input  logic [3:0]        bus_be,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic              rd_en,
    input  logic              rd_zero,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [31:0] mem [DEPTH];

    // Both write ports share one process so the loader's assignment, being
    // last, overrides a bus write to the same word on the same edge.
    always_ff @(posedge clk) begin
        if (bus_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus_be[i]) begin
                    mem[bus_addr][8*i +: 8] <= bus_data[8*i +: 8];
                end
            end
        end
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    // Read-before-write: a word written on the same edge reads as its old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 32'd0;
        end else if (rd_en) begin
            rd_data <= rd_zero ? 32'd0 : mem[rd_addr];
        end
    end

endmodule

// File: rtl/avalon_wait_ram.sv
// -----------------------------------------------------------------------------
// avalon_wait_ram
//
// Avalon-MM slave memory with a programmable number of wait states per
// transfer, plus a side-band loader port.
//
// Handshake: a transfer is requested by holding read and/or write high; the
// master keeps address/writedata/byteenable stable while waitrequest is high;
// the transfer completes in the one cycle where the request is high and
// waitrequest is low (ACK), with readdata and err valid in that cycle.
//
// Parameters:
//   ADDR_W      - word-index width, array depth 2^ADDR_W
//   BASE_ADDR   - byte address of word 0, aligned to 2^(ADDR_W+2)
//   WAIT_CYCLES - stall cycles inserted between IDLE and ACK (0..15)
//
// Ports:
//   clk, reset                    - clock; async active-low reset
//   address, read, write,
//   writedata, byteenable         - Avalon-MM request
//   waitrequest, readdata         - Avalon-MM response
//   load_en, load_addr, load_data - loader word write, any state
//   err                           - one-cycle pulse in ACK of a faulty transfer
//   fsm_state                     - current FSM state, for observation
// -----------------------------------------------------------------------------
module avalon_wait_ram
    import avalon_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic              waitrequest,
    output logic [31:0]       readdata,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic              err,
    output state_t            fsm_state
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic             NO_WAIT   = (WAIT_CYCLES == 0);

    state_t            state;
    logic [CNT_W-1:0]  cnt;

    // Request captured in IDLE; later cycles use these, not the live bus.
    logic [ADDR_W-1:0] lat_idx;
    logic              lat_addr_bad;
    logic              lat_both;
    logic              lat_write;
    logic [31:0]       lat_data;
    logic [3:0]        lat_be;

    logic              req;
    logic [ADDR_W-1:0] live_idx;
    logic              live_addr_bad;
    logic              live_both;

    logic              enter_ack;
    logic [ADDR_W-1:0] sel_idx;
    logic              sel_addr_bad;
    logic              sel_both;
    logic              bus_we;

    assign req       = read | write;
    assign live_both = read & write;

    // BASE_ADDR is window-aligned, so (address - BASE_ADDR) >> 2 is simply
    // the word-index field of the address once it is known to be in range.
    assign live_idx      = address[ADDR_W+1:2];
    assign live_addr_bad = !in_window(address, BASE_ADDR, ADDR_W) ||
                           (address[1:0] != 2'b00);

    // Decode that applies on the edge into ACK. With no wait states that
    // edge leaves IDLE, before the latches hold anything, so use the live bus.
    always_comb begin
        enter_ack    = 1'b0;
        sel_idx      = lat_idx;
        sel_addr_bad = lat_addr_bad;
        sel_both     = lat_both;
        case (state)
            IDLE: begin
                sel_idx      = live_idx;
                sel_addr_bad = live_addr_bad;
                sel_both     = live_both;
                enter_ack    = req && NO_WAIT;
            end
            WAIT: begin
                enter_ack = req && (cnt == CNT_ONE);
            end
            default: begin
                enter_ack = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            err          <= 1'b0;
            lat_idx      <= '0;
            lat_addr_bad <= 1'b0;
            lat_both     <= 1'b0;
            lat_write    <= 1'b0;
            lat_data     <= 32'd0;
            lat_be       <= 4'd0;
        end else begin
            // Registered so it is high for exactly the ACK cycle.
            err <= enter_ack && (sel_addr_bad || sel_both);

            case (state)
                IDLE: begin
                    if (req) begin
                        lat_idx      <= live_idx;
                        lat_addr_bad <= live_addr_bad;
                        lat_both     <= live_both;
                        lat_write    <= write;
                        lat_data     <= writedata;
                        lat_be       <= byteenable;
                        cnt          <= WAIT_LOAD;
                        state        <= NO_WAIT ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    if (!req) begin
                        // Abandoned request: nothing has been committed yet.
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE) begin
                            state <= ACK;
                        end
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write lands at the end of ACK; a faulty address drops it entirely.
    assign bus_we = (state == ACK) && lat_write && !lat_addr_bad;

    mem_word_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk       (clk),
        .rst_n     (reset),
        .bus_we    (bus_we),
        .bus_addr  (lat_idx),
        .bus_data  (lat_data),
        .bus_be    (lat_be),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .rd_en     (enter_ack),
        .rd_zero   (sel_addr_bad),
        .rd_addr   (sel_idx),
        .rd_data   (readdata)
    );

    // Stall every requested cycle except ACK; hold the master off in reset.
    assign waitrequest = !reset || (req && (state != ACK));
    assign fsm_state   = state;

endmodule

// File: tb/tb_avalon_wait_ram.sv
// -----------------------------------------------------------------------------
// tb_avalon_wait_ram
//
// Main DUT uses WAIT_CYCLES=2; two extra instances (WAIT_CYCLES=3 and 0)
// measure stall length. Driver tasks push the expected {check_rd, err, data}
// for each bus transfer; a monitor pops and compares on every completing cycle.
// -----------------------------------------------------------------------------
module tb_avalon_wait_ram;
    import avalon_mem_pkg::*;

    localparam int MAIN_WAIT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;

    logic        waitrequest;
    logic [31:0] readdata;
    logic        err;
    state_t      fsm_state;

    logic        read3, write3, wait3, err3;
    logic [31:0] rdata3;
    state_t      st3;
    logic        read0, write0, wait0, err0;
    logic [31:0] rdata0;
    state_t      st0;

    int vectors = 0;
    int fails   = 0;

    logic [33:0] exp_q[$];
    logic [33:0] mon_exp;

    always #5 clk = ~clk;

    avalon_wait_ram #(.ADDR_W(8), .BASE_ADDR(32'hBFC0_0000), .WAIT_CYCLES(MAIN_WAIT)) dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
        .readdata(readdata), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .err(err), .fsm_state(fsm_state)
    );

    avalon_wait_ram #(.ADDR_W(8), .BASE_ADDR(32'hBFC0_0000), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .address(address), .read(read3), .write(write3),
        .writedata(writedata), .byteenable(byteenable), .waitrequest(wait3),
        .readdata(rdata3), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .err(err3), .fsm_state(st3)
    );

    avalon_wait_ram #(.ADDR_W(8), .BASE_ADDR(32'hBFC0_0000), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .address(address), .read(read0), .write(write0),
        .writedata(writedata), .byteenable(byteenable), .waitrequest(wait0),
        .readdata(rdata0), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .err(err0), .fsm_state(st0)
    );

    // Monitor: every completing cycle of the main DUT must match the queue head.
    always @(negedge clk) begin
        if (reset && (read || write) && !waitrequest) begin
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_ack: got err=%0b rd=%h, want no completion", err, readdata);
            end else begin
                mon_exp = exp_q.pop_front();
                vectors++;
                if ((err !== mon_exp[32]) || (mon_exp[33] && (readdata !== mon_exp[31:0]))) begin
                    fails++;
                    $display("FAIL xfer_resp: got err=%0b rd=%h, want err=%0b rd=%h (rd checked=%0b)",
                             err, readdata, mon_exp[32], mon_exp[31:0], mon_exp[33]);
                end
            end
        end else if (reset && err) begin
            fails++;
            $display("FAIL stray_err: got err=1 outside a completing cycle, want 0");
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic load_word(input logic [7:0] idx, input logic [31:0] data);
        @(posedge clk); #1;
        load_en = 1'b1; load_addr = idx; load_data = data;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    // One main-DUT transfer; optionally fires the loader at index 12 on the
    // same edge that ends ACK.
    task automatic bus_xfer(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] be,
                            input logic [31:0] exp_rd, input logic exp_err,
                            input logic collide, input logic [31:0] ldata);
        int  waits;
        bit  done;
        exp_q.push_back({rd & ~wr, exp_err, exp_rd});
        @(posedge clk); #1;
        read = rd; write = wr; address = addr; writedata = data; byteenable = be;
        waits = 0;
        done  = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (waitrequest) waits++;
            else done = 1'b1;
        end
        if (!done) begin
            fails++;
            $display("FAIL xfer_timeout: got no ACK in 40 cycles, want ACK for addr %h", addr);
            void'(exp_q.pop_back());
        end else begin
            check("main_wait_cycles", 32'(waits), 32'(1 + MAIN_WAIT));
            if (collide) begin
                load_en = 1'b1; load_addr = 8'd12; load_data = ldata;
            end
        end
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0; load_en = 1'b0;
    endtask

    // Counts stalled cycles of a read on one of the side instances.
    task automatic count_wait(input int sel, output int n);
        bit done;
        n    = 0;
        done = 1'b0;
        @(posedge clk); #1;
        address = 32'hBFC0_0030;
        if (sel == 3) read3 = 1'b1;
        else          read0 = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if ((sel == 3) ? wait3 : wait0) n++;
            else done = 1'b1;
        end
        if (!done) n = -1;
        @(posedge clk); #1;
        read3 = 1'b0; read0 = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b0;
        read = 1'b0; write = 1'b0; address = 32'd0; writedata = 32'd0; byteenable = 4'd0;
        load_en = 1'b0; load_addr = 8'd0; load_data = 32'd0;
        read3 = 1'b0; write3 = 1'b0; read0 = 1'b0; write0 = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_waitrequest", 32'(waitrequest), 32'd1);
        check("reset_readdata", readdata, 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_state", 32'(fsm_state), 32'(IDLE));
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("idle_waitrequest", 32'(waitrequest), 32'd0);

        // Preload words used below
        load_word(8'd12, 32'h1122_3344);
        load_word(8'd255, 32'h8765_4321);
        load_word(8'd0, 32'h0000_0000);

        // Basic read, partial write, read back
        bus_xfer(1, 0, 32'hBFC0_0030, 32'd0, 4'h0, 32'h1122_3344, 0, 0, 32'd0);
        bus_xfer(0, 1, 32'hBFC0_0030, 32'hAAAA_BBBB, 4'b0011, 32'd0, 0, 0, 32'd0);
        bus_xfer(1, 0, 32'hBFC0_0030, 32'd0, 4'h0, 32'h1122_BBBB, 0, 0, 32'd0);

        // Faulty transfers: out-of-range read, misaligned write dropped
        bus_xfer(1, 0, 32'h0000_0000, 32'd0, 4'h0, 32'd0, 1, 0, 32'd0);
        bus_xfer(0, 1, 32'hBFC0_0031, 32'hFFFF_FFFF, 4'hF, 32'd0, 1, 0, 32'd0);
        bus_xfer(1, 0, 32'hBFC0_0030, 32'd0, 4'h0, 32'h1122_BBBB, 0, 0, 32'd0);
        bus_xfer(1, 0, 32'hBFC0_0400, 32'd0, 4'h0, 32'd0, 1, 0, 32'd0);

        // read+write together acts as a write and flags err
        bus_xfer(1, 1, 32'hBFC0_0034, 32'h5A5A_5A5A, 4'hF, 32'd0, 1, 0, 32'd0);
        bus_xfer(1, 0, 32'hBFC0_0034, 32'd0, 4'h0, 32'h5A5A_5A5A, 0, 0, 32'd0);

        // Zero byteenable: acknowledged, nothing written
        bus_xfer(0, 1, 32'hBFC0_0030, 32'hFFFF_FFFF, 4'b0000, 32'd0, 0, 0, 32'd0);
        bus_xfer(1, 0, 32'hBFC0_0030, 32'd0, 4'h0, 32'h1122_BBBB, 0, 0, 32'd0);

        // Window edges: last word, and upper lanes of word 0
        bus_xfer(1, 0, 32'hBFC0_03FC, 32'd0, 4'h0, 32'h8765_4321, 0, 0, 32'd0);
        bus_xfer(0, 1, 32'hBFC0_0000, 32'h1234_5678, 4'b1100, 32'd0, 0, 0, 32'd0);
        bus_xfer(1, 0, 32'hBFC0_0000, 32'd0, 4'h0, 32'h1234_0000, 0, 0, 32'd0);

        // Reset during WAIT aborts the write
        @(posedge clk); #1;
        write = 1'b1; address = 32'hBFC0_0030; writedata = 32'hDEAD_BEEF; byteenable = 4'hF;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midreset_waitrequest", 32'(waitrequest), 32'd1);
        check("midreset_readdata", readdata, 32'd0);
        check("midreset_state", 32'(fsm_state), 32'(IDLE));
        @(posedge clk); #1;
        write = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        bus_xfer(1, 0, 32'hBFC0_0030, 32'd0, 4'h0, 32'h1122_BBBB, 0, 0, 32'd0);

        // Loader collides with the committing bus write: loader wins
        bus_xfer(0, 1, 32'hBFC0_0030, 32'h0101_0101, 4'hF, 32'd0, 0, 1, 32'hCAFE_F00D);
        bus_xfer(1, 0, 32'hBFC0_0030, 32'd0, 4'h0, 32'hCAFE_F00D, 0, 0, 32'd0);

        // Stall length on the other wait-state settings
        count_wait(3, n);
        check("wait3_stall_cycles", 32'(n), 32'd4);
        count_wait(0, n);
        check("wait0_stall_cycles", 32'(n), 32'd1);

        repeat (4) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
